// File: rtl/instr_decode_pkg.sv
// Shared command-format constants and decoder state encoding for the PWM
// register path; the register file uses the same address constants.
package instr_decode_pkg;
  localparam int CMD_ADDR_W   = 6;
  localparam int CMD_DATA_W   = 8;
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic {
    ST_CMD  = 1'b0,
    ST_DATA = 1'b1
  } state_e;
endpackage

// File: rtl/instr_decode.sv
// Byte-stream command decoder: first byte of a frame is R/W + start address,
// following bytes are written or streamed back as register reads.
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int ADDR_W   = CMD_ADDR_W,
  parameter int DATA_W   = CMD_DATA_W,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_active,
  input  logic              i_byte_sync,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_read,
  output logic              o_write,
  output logic [DATA_W-1:0] o_data_write,
  input  logic [DATA_W-1:0] i_data_read
);

  state_e              r_state, w_state_nxt;
  logic                r_rw, w_rw_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_data_out, w_data_out_nxt;
  logic [DATA_W-1:0]   r_data_write, w_data_write_nxt;
  logic                r_read, w_read_nxt;
  logic                r_write, w_write_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_CMD;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_frame_active)                     w_state_nxt = ST_CMD;
    else if (i_byte_sync && r_state == ST_CMD) w_state_nxt = ST_DATA;
  end

  // Next values for the registered bus outputs. A write's address advance is
  // deferred one cycle so the strobe still sees the pre-increment address.
  always_comb begin
    w_rw_nxt         = r_rw;
    w_addr_nxt       = r_addr;
    w_data_out_nxt   = r_data_out;
    w_data_write_nxt = r_data_write;
    w_read_nxt       = 1'b0;
    w_write_nxt      = 1'b0;
    if (!i_frame_active) begin
      w_data_out_nxt = '0;
    end else begin
      if (r_read) w_data_out_nxt = i_data_read;
      if (AUTO_INC && r_write) w_addr_nxt = r_addr + ADDR_W'(1);
      if (i_byte_sync) begin
        if (r_state == ST_CMD) begin
          w_rw_nxt   = i_data_in[CMD_RW_BIT];
          w_addr_nxt = i_data_in[CMD_ADDR_LSB +: ADDR_W];
          w_read_nxt = ~i_data_in[CMD_RW_BIT];
        end else if (r_rw) begin
          w_write_nxt      = 1'b1;
          w_data_write_nxt = i_data_in;
        end else begin
          // Incoming byte is a dummy; advance first so the stream continues.
          w_read_nxt = 1'b1;
          if (AUTO_INC) w_addr_nxt = r_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_data_out   <= '0;
      r_data_write <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      r_rw         <= w_rw_nxt;
      r_addr       <= w_addr_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_write <= w_data_write_nxt;
      r_read       <= w_read_nxt;
      r_write      <= w_write_nxt;
    end
  end

  assign o_data_out   = r_data_out;
  assign o_addr       = r_addr;
  assign o_read       = r_read;
  assign o_write      = r_write;
  assign o_data_write = r_data_write;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: two instances (auto-increment on/off) share
// stimulus; strobes are checked against scoreboard queues as they appear.
module tb_instr_decode;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_active;
  logic       byte_sync;
  logic [7:0] data_in;

  logic [7:0] dout_a, dout_b, dw_a, dw_b, dr_a, dr_b;
  logic [5:0] addr_a, addr_b;
  logic       rd_a, rd_b, wr_a, wr_b;

  logic [7:0] mem [64];
  assign dr_a = mem[addr_a];
  assign dr_b = mem[addr_b];

  int tests = 0;
  int fails = 0;

  wr_t        qwa[$], qwb[$];
  logic [5:0] qra[$], qrb[$];
  wr_t        ea, eb;
  logic [5:0] ra, rb;

  always #5 clk = ~clk;

  instr_decode #(.AUTO_INC(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_active(frame_active),
    .i_byte_sync(byte_sync), .i_data_in(data_in), .o_data_out(dout_a),
    .o_addr(addr_a), .o_read(rd_a), .o_write(wr_a), .o_data_write(dw_a),
    .i_data_read(dr_a)
  );

  instr_decode #(.AUTO_INC(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_active(frame_active),
    .i_byte_sync(byte_sync), .i_data_in(data_in), .o_data_out(dout_b),
    .o_addr(addr_b), .o_read(rd_b), .o_write(wr_b), .o_data_write(dw_b),
    .i_data_read(dr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle N+1, 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    byte_sync = 1'b1;
    data_in   = b;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic push_wr(input logic [5:0] aa, input logic [5:0] ab, input logic [7:0] d);
    qwa.push_back('{a: aa, d: d});
    qwb.push_back('{a: ab, d: d});
  endtask

  // Strobe monitor: every read/write pulse must match the next queued entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_a || wr_a) chk("a_exclusive", {31'b0, rd_a & wr_a}, 0);
      if (rd_b || wr_b) chk("b_exclusive", {31'b0, rd_b & wr_b}, 0);
      if (wr_a) begin
        chk("a_wr_expected", {31'b0, qwa.size() != 0}, 1);
        if (qwa.size() != 0) begin
          ea = qwa.pop_front();
          chk("a_wr_addr", {26'b0, addr_a}, {26'b0, ea.a});
          chk("a_wr_data", {24'b0, dw_a}, {24'b0, ea.d});
        end
      end
      if (wr_b) begin
        chk("b_wr_expected", {31'b0, qwb.size() != 0}, 1);
        if (qwb.size() != 0) begin
          eb = qwb.pop_front();
          chk("b_wr_addr", {26'b0, addr_b}, {26'b0, eb.a});
          chk("b_wr_data", {24'b0, dw_b}, {24'b0, eb.d});
        end
      end
      if (rd_a) begin
        chk("a_rd_expected", {31'b0, qra.size() != 0}, 1);
        if (qra.size() != 0) begin
          ra = qra.pop_front();
          chk("a_rd_addr", {26'b0, addr_a}, {26'b0, ra});
        end
      end
      if (rd_b) begin
        chk("b_rd_expected", {31'b0, qrb.size() != 0}, 1);
        if (qrb.size() != 0) begin
          rb = qrb.pop_front();
          chk("b_rd_addr", {26'b0, addr_b}, {26'b0, rb});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
    mem[5]  = 8'hA7;
    mem[6]  = 8'h5B;
    mem[7]  = 8'hC3;
    mem[13] = 8'h6E;

    rst_n = 1'b0; frame_active = 1'b0; byte_sync = 1'b0; data_in = 8'h00;
    idle(2);
    chk("rst_data_out",   {24'b0, dout_a}, 0);
    chk("rst_addr",       {26'b0, addr_a}, 0);
    chk("rst_data_write", {24'b0, dw_a},   0);
    chk("rst_read",       {31'b0, rd_a},   0);
    chk("rst_write",      {31'b0, wr_a},   0);
    rst_n = 1'b1;
    idle(2);

    // Write frame 0x85, 0x3C
    frame_active = 1'b1;
    idle(2);
    send(8'h85);
    chk("wcmd_addr", {26'b0, addr_a}, 5);
    chk("wcmd_read", {31'b0, rd_a},   0);
    idle(3);
    push_wr(6'd5, 6'd5, 8'h3C);
    send(8'h3C);
    chk("wdat_write", {31'b0, wr_a}, 1);
    chk("wdat_addr",  {26'b0, addr_a}, 5);
    chk("wdat_data",  {24'b0, dw_a}, 8'h3C);
    idle(1);
    chk("wdat_write_width", {31'b0, wr_a}, 0);
    chk("wdat_addr_inc",    {26'b0, addr_a}, 6);
    chk("wdat_addr_hold_b", {26'b0, addr_b}, 5);
    frame_active = 1'b0;
    idle(2);

    // Read frame 0x05, 0x00
    frame_active = 1'b1;
    idle(1);
    qra.push_back(6'd5); qrb.push_back(6'd5);
    send(8'h05);
    chk("rcmd_read", {31'b0, rd_a},   1);
    chk("rcmd_addr", {26'b0, addr_a}, 5);
    idle(1);
    chk("rcmd_dout",       {24'b0, dout_a}, 8'hA7);
    chk("rcmd_read_width", {31'b0, rd_a},   0);
    idle(2);
    qra.push_back(6'd6); qrb.push_back(6'd5);
    send(8'h00);
    chk("rdat_addr_inc", {26'b0, addr_a}, 6);
    chk("rdat_read",     {31'b0, rd_a},   1);
    idle(1);
    chk("rdat_dout_a", {24'b0, dout_a}, 8'h5B);
    chk("rdat_dout_b", {24'b0, dout_b}, 8'hA7);
    frame_active = 1'b0;
    idle(1);
    chk("frame_end_dout", {24'b0, dout_a}, 0);
    chk("frame_end_addr_hold", {26'b0, addr_a}, 6);
    idle(1);

    // Burst write with address wrap
    frame_active = 1'b1;
    idle(1);
    send(8'hBE);
    idle(3);
    push_wr(6'd62, 6'd62, 8'h11); send(8'h11); idle(3);
    push_wr(6'd63, 6'd62, 8'h22); send(8'h22); idle(3);
    push_wr(6'd0,  6'd62, 8'h33); send(8'h33);
    idle(1);
    chk("burst_wrap_addr_a", {26'b0, addr_a}, 1);
    chk("burst_addr_b",      {26'b0, addr_b}, 62);
    chk("burst_last_data",   {24'b0, dw_a},   8'h33);
    frame_active = 1'b0;
    idle(2);

    // Aborted frame: command only
    frame_active = 1'b1;
    idle(1);
    send(8'h8A);
    idle(1);
    frame_active = 1'b0;
    idle(3);
    chk("abort_dout", {24'b0, dout_a}, 0);
    chk("abort_addr", {26'b0, addr_a}, 10);
    frame_active = 1'b1;
    idle(1);
    qra.push_back(6'd7); qrb.push_back(6'd7);
    send(8'h07);
    chk("abort_next_cmd_addr", {26'b0, addr_a}, 7);
    chk("abort_next_cmd_read", {31'b0, rd_a},   1);
    idle(1);
    chk("abort_next_dout", {24'b0, dout_a}, 8'hC3);
    idle(2);

    // byte_sync in the same cycle frame_active drops
    frame_active = 1'b0;
    send(8'h90);
    chk("simul_addr",  {26'b0, addr_a}, 7);
    chk("simul_read",  {31'b0, rd_a},   0);
    chk("simul_dout",  {24'b0, dout_a}, 0);
    idle(2);
    frame_active = 1'b1;
    idle(1);
    send(8'h88);
    idle(3);
    push_wr(6'd8, 6'd8, 8'h44);
    send(8'h44);
    chk("simul_after_write", {31'b0, wr_a}, 1);
    idle(2);
    frame_active = 1'b0;
    idle(2);

    // Reset between command and data byte
    frame_active = 1'b1;
    idle(1);
    send(8'h8C);
    chk("mid_cmd_addr", {26'b0, addr_a}, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr",       {26'b0, addr_a}, 0);
    chk("mid_rst_data_out",   {24'b0, dout_a}, 0);
    chk("mid_rst_data_write", {24'b0, dw_a},   0);
    chk("mid_rst_write",      {31'b0, wr_a},   0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    qra.push_back(6'd13); qrb.push_back(6'd13);
    send(8'h0D);
    chk("post_rst_cmd_addr", {26'b0, addr_a}, 13);
    chk("post_rst_cmd_read", {31'b0, rd_a},   1);
    idle(1);
    chk("post_rst_dout", {24'b0, dout_a}, 8'h6E);
    frame_active = 1'b0;
    idle(3);

    chk("qwa_drained", qwa.size(), 0);
    chk("qwb_drained", qwb.size(), 0);
    chk("qra_drained", qra.size(), 0);
    chk("qrb_drained", qrb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
